// File: rtl/dmem_port_arbiter_pkg.sv
// Shared owner encodings and defaults for the data-memory port arbiter.
// Owner codes are also used as the registered "who had the port last cycle" tag.
package dmem_port_arbiter_pkg;

    typedef logic [1:0] owner_t;

    localparam owner_t ARB_NONE = 2'd0;
    localparam owner_t ARB_CPU  = 2'd1;
    localparam owner_t ARB_M1   = 2'd2;

    localparam int unsigned STARVE_MAX_DEFAULT = 4;
    localparam int unsigned CNT_W_DEFAULT      = 4;

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Saturating count of consecutive cycles master 1 was refused the port.
// The clear input wins over increment.
module dmem_arb_starve_cnt #(
    parameter int unsigned MAX = 4,
    parameter int unsigned W   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [W-1:0] MaxVal = W'(MAX);

    logic [W-1:0] cnt_q, cnt_d;

    assign sat = (cnt_q == MaxVal);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !sat) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the synchronous data-RAM port between the CPU memory stage and a second
// master, stalling the CPU when master 1 takes the port and steering read data back.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT,
    parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wr_en,
    output logic [31:0] cpu_rdata,
    output logic        cpu_pause,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wr_en,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wr_en,
    input  logic [31:0] mem_rdata
);

    owner_t      grant;
    owner_t      prev_owner_q;
    logic        prev_rd_q, prev_rd_d;
    logic [31:0] cpu_rdata_q;
    logic        starve_sat;

    // Master 1 wins an idle port, or pre-empts the CPU once it has starved long enough.
    always_comb begin
        grant = ARB_NONE;
        if (m1_req && (!cpu_req || starve_sat)) begin
            grant = ARB_M1;
        end else if (cpu_req) begin
            grant = ARB_CPU;
        end
    end

    assign m1_gnt    = (grant == ARB_M1);
    assign cpu_pause = cpu_req & m1_gnt;

    dmem_arb_starve_cnt #(
        .MAX (STARVE_MAX),
        .W   (CNT_W)
    ) u_starve_cnt (
        .clk (clk),
        .rst (rst),
        .inc (m1_req & ~m1_gnt),
        .clr (m1_gnt | ~m1_req),
        .sat (starve_sat)
    );

    // An idle port still presents the CPU address but never writes.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_wr_en = '0;
        case (grant)
            ARB_CPU: mem_wr_en = cpu_wr_en;
            ARB_M1: begin
                mem_addr  = m1_addr;
                mem_wdata = m1_wdata;
                mem_wr_en = m1_wr_en;
            end
            default: ;
        endcase
    end

    assign prev_rd_d = (grant != ARB_NONE) && (mem_wr_en == 4'b0000);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_owner_q <= ARB_NONE;
            prev_rd_q    <= 1'b0;
            cpu_rdata_q  <= '0;
        end else begin
            prev_owner_q <= grant;
            prev_rd_q    <= prev_rd_d;
            if (prev_owner_q == ARB_CPU) begin
                cpu_rdata_q <= mem_rdata;
            end
        end
    end

    // Holding the last CPU-owned RAM word keeps CPU data stable across pauses.
    assign cpu_rdata = (prev_owner_q == ARB_CPU) ? mem_rdata : cpu_rdata_q;
    assign m1_rvalid = (prev_owner_q == ARB_M1) && prev_rd_q;
    assign m1_rdata  = mem_rdata;

endmodule
